// File: rtl/ds_sample_scheduler.sv
// Sample scheduler for the delta-sigma PWM modulator: buffers host samples in a small FIFO
// and advances u every 2^k modulator pulses, optionally interpolating linearly in between.
module ds_sample_scheduler #(
    parameter int SAMPLE_BITS = 16,
    parameter int IN_BITS     = 23,
    parameter int FIFO_LOG2   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [SAMPLE_BITS-1:0] in_data,
    output logic                   in_ready,
    input  logic                   enable,
    input  logic [2:0]             period_log2,
    input  logic                   interp_en,
    input  logic                   clear_underrun,
    input  logic                   pulse_done,
    output logic [IN_BITS-1:0]     u,
    output logic                   sample_tick,
    output logic                   underrun,
    output logic [FIFO_LOG2:0]     fifo_level
);
    localparam int FRAC  = IN_BITS - SAMPLE_BITS;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [SAMPLE_BITS-1:0] MID = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t state, state_next;

    logic [SAMPLE_BITS-1:0] mem [DEPTH];
    logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr;
    logic                   fifo_empty, fifo_full, push, pop;
    logic [SAMPLE_BITS-1:0] head;

    logic [SAMPLE_BITS-1:0] base;
    logic signed [IN_BITS-1:0] step;
    logic [FRAC-1:0]        cnt;
    logic [2:0]             k_cur;
    logic [FRAC:0]          cnt_last;
    logic                   counting, load_k, tick;

    logic signed [SAMPLE_BITS:0]  delta;
    logic signed [IN_BITS-1:0]    delta_ext, step_new;

    // Handshake: a sample transfers on a cycle where in_valid && in_ready; data is taken with it.
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == (FIFO_LOG2+1)'(DEPTH));
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign pop        = tick && !fifo_empty;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable)
            state_next = IDLE;
        else begin
            case (state)
                IDLE:    state_next = PRIME;
                PRIME:   if (!fifo_empty) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        counting = (state == RUN) && enable;
        load_k   = (state == PRIME) && (state_next == RUN);
        cnt_last = ((FRAC+1)'(1) << k_cur) - 1'b1;
        tick     = counting && pulse_done && (cnt == cnt_last[FRAC-1:0]);
    end

    // Interpolation step spreads (s - base) over 2^k pulses in the fractional bits of u.
    always_comb begin
        delta     = $signed({1'b0, head}) - $signed({1'b0, base});
        delta_ext = {{(IN_BITS-SAMPLE_BITS-1){delta[SAMPLE_BITS]}}, delta};
        step_new  = delta_ext <<< (3'(FRAC) - period_log2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            u           <= {MID, {FRAC{1'b0}}};
            base        <= MID;
            step        <= '0;
            cnt         <= '0;
            k_cur       <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= tick;
            if (load_k)
                k_cur <= period_log2;
            if (!counting)
                cnt <= '0;
            else if (pulse_done) begin
                if (tick) begin
                    cnt   <= '0;
                    k_cur <= period_log2;
                    if (!fifo_empty) begin
                        base <= head;
                        if (interp_en) begin
                            u    <= {base, {FRAC{1'b0}}};
                            step <= step_new;
                        end else begin
                            u    <= {head, {FRAC{1'b0}}};
                            step <= '0;
                        end
                    end else begin
                        u    <= {base, {FRAC{1'b0}}};
                        step <= '0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    u   <= u + $unsigned(step);
                end
            end
            if (tick && fifo_empty)
                underrun <= 1'b1;
            else if (clear_underrun)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ds_sample_scheduler.sv
// Bench for ds_sample_scheduler: directed scenarios plus a random run, all checked every
// cycle against a queue-based behavioural model of the scheduler.
module tb_ds_sample_scheduler;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, enable, interp_en, clear_underrun, pulse_done;
    logic [15:0] in_data;
    logic [2:0]  period_log2;
    logic [22:0] u;
    logic        sample_tick, underrun;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    // model: mode 0 idle, 1 waiting for data, 2 running
    int m_mode, m_u, m_base, m_step, m_cnt, m_k;
    bit m_under, m_tick;
    int q[$];

    always #5 clk = ~clk;

    ds_sample_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .enable(enable), .period_log2(period_log2), .interp_en(interp_en),
        .clear_underrun(clear_underrun), .pulse_done(pulse_done), .u(u),
        .sample_tick(sample_tick), .underrun(underrun), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int n;
        bit tick, set_u;
        if (reset) begin
            m_mode = 0; m_base = 32'h8000; m_u = 32'h8000 * 128; m_step = 0;
            m_cnt = 0; m_k = 0; m_under = 0; m_tick = 0;
            q.delete();
            return;
        end
        n     = q.size();
        tick  = (m_mode == 2) && enable && pulse_done && (m_cnt == (1 << m_k) - 1);
        set_u = tick && (n == 0);
        if (!enable) begin
            m_mode = 0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (n >= 1) begin
                m_mode = 2;
                m_k    = period_log2;
            end
        end else if (pulse_done) begin
            if (tick) begin
                m_cnt = 0;
                m_k   = period_log2;
                if (n > 0) begin
                    int s;
                    s = q.pop_front();
                    if (interp_en) begin
                        m_u    = m_base * 128;
                        m_step = (s - m_base) * (1 << (7 - int'(period_log2)));
                    end else begin
                        m_u    = s * 128;
                        m_step = 0;
                    end
                    m_base = s;
                end else begin
                    m_u    = m_base * 128;
                    m_step = 0;
                end
            end else begin
                m_cnt = m_cnt + 1;
                m_u   = m_u + m_step;
            end
        end
        if (in_valid && n < 4)
            q.push_back(int'(in_data));
        if (set_u)
            m_under = 1;
        else if (clear_underrun)
            m_under = 0;
        m_tick = tick;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (sample_tick === 1'b1) ticks++;
        chk("u", 32'(u), m_u & 32'h7fffff);
        chk("sample_tick", 32'(sample_tick), 32'(m_tick));
        chk("underrun", 32'(underrun), 32'(m_under));
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("in_ready", 32'(in_ready), 32'(q.size() < 4));
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1; in_data = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic pulse();
        pulse_done = 1'b1;
        cycle();
        pulse_done = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic start(input logic [2:0] k, input logic ip);
        period_log2 = k; interp_en = ip; enable = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        int t0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0; period_log2 = '0;
        interp_en = 1'b0; clear_underrun = 1'b0; pulse_done = 1'b0;

        // reset state, with in_valid held high to show it is ignored
        in_valid = 1'b1; in_data = 16'h1234;
        cycle(); cycle();
        in_valid = 1'b0;
        reset = 1'b0;
        chk("reset_u", 32'(u), 32'h400000);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_ready", 32'(in_ready), 1);
        chk("reset_underrun", 32'(underrun), 0);

        // zero-order hold, k=2
        push(16'h1000); push(16'h2000);
        start(3'd2, 1'b0);
        t0 = ticks;
        repeat (4) pulse();
        chk("zoh_u_first", 32'(u), 32'h080000);
        repeat (4) pulse();
        chk("zoh_u_second", 32'(u), 32'h100000);
        chk("zoh_ticks", ticks - t0, 2);

        // interpolation from midscale toward 0x8002, k=1
        do_reset();
        push(16'h8002);
        start(3'd1, 1'b1);
        pulse(); pulse();
        chk("interp_tick_u", 32'(u), 32'h400000);
        pulse();
        chk("interp_step_u", 32'(u), 32'h400080);
        pulse();
        chk("interp_target_u", 32'(u), 32'h400100);
        chk("interp_underrun", 32'(underrun), 1);
        clear_underrun = 1'b1; cycle(); clear_underrun = 1'b0;
        chk("underrun_cleared", 32'(underrun), 0);

        // overflow drop, drain, underrun
        do_reset();
        for (int i = 1; i <= 5; i++) push(16'(i * 16'h0101));
        chk("full_level", 32'(fifo_level), 4);
        chk("full_ready", 32'(in_ready), 0);
        start(3'd0, 1'b0);
        repeat (4) pulse();
        chk("drain_level", 32'(fifo_level), 0);
        chk("drain_u", 32'(u), 32'h020200);
        pulse();
        chk("empty_underrun", 32'(underrun), 1);
        chk("empty_u_held", 32'(u), 32'h020200);

        // enable drop mid-period
        do_reset();
        push(16'h1111); push(16'h2222); push(16'h3333);
        start(3'd2, 1'b0);
        repeat (4) pulse();
        repeat (2) pulse();
        enable = 1'b0; cycle(); cycle();
        chk("idle_u_held", 32'(u), 32'h088880);
        start(3'd2, 1'b0);
        t0 = ticks;
        repeat (3) pulse();
        chk("reenable_no_tick", ticks - t0, 0);
        pulse();
        chk("reenable_tick", ticks - t0, 1);
        chk("reenable_u", 32'(u), 32'h111100);

        // period change takes effect only at the next tick
        do_reset();
        push(16'h0100); push(16'h0200); push(16'h0300);
        start(3'd3, 1'b0);
        t0 = ticks;
        repeat (3) pulse();
        period_log2 = 3'd0;
        repeat (4) pulse();
        chk("k_change_no_tick", ticks - t0, 0);
        pulse();
        chk("k_change_tick8", ticks - t0, 1);
        pulse();
        chk("k_change_tick1", ticks - t0, 2);

        // random run against the model
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            in_valid       = ($urandom_range(0, 2) == 0);
            in_data        = 16'($urandom);
            pulse_done     = ($urandom_range(0, 1) == 1);
            clear_underrun = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) period_log2 = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) interp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) period_log2 = 3'd7;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
